demux_1to4_buf: RTL and testbench

//   Buffered 1-to-4 demultiplexer: the write/steer direction of the 4:1 mux

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_slot.sv | 33 +++
 rtl/demux_1to4_buf.sv | 54 +++++
 tb/tb_demux_1to4_buf.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demux.
// Channel count, select width and select decode.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  function automatic logic [NUM_OUT-1:0] sel_to_onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [NUM_OUT-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demux: a single-entry register.
// A load on the same edge as a pop replaces the word with no bubble.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  assign ready = ~valid | pop;

  // data is kept after a pop; only valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer with valid/ready on both sides.
// Steers each accepted word to the slot addressed by in_sel.
module demux_1to4_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [CNT_W-1:0]          accept_cnt
);

  logic [NUM_OUT-1:0] sel_oh;
  logic [NUM_OUT-1:0] slot_rdy;
  logic [NUM_OUT-1:0] load;
  logic               accept;

  assign sel_oh   = sel_to_onehot(in_sel);
  assign in_ready = slot_rdy[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = sel_oh & {NUM_OUT{accept}};

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[k]),
      .pop  (out_ready[k]),
      .din  (in_data),
      .valid(out_valid[k]),
      .data (out_data[k*DATA_W +: DATA_W]),
      .ready(slot_rdy[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: directed table, reset and wrap sequences,
// then random traffic against a slot-array reference model.
module tb_demux_1to4_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  accept_cnt;

  demux_1to4_buf #(.DATA_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [1:0]  s;
    logic        v;
    logic [3:0]  r;
    logic        erdy;
    logic [3:0]  eov;
    logic [15:0] edata;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vec[13];

  int n_chk  = 0;
  int n_fail = 0;

  bit         mv[4];
  logic [3:0] md[4];
  int         mcnt;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic m_rdy(input logic [1:0] s, input logic [3:0] r);
    return !mv[s] || r[s];
  endfunction

  function automatic logic [3:0] m_ov();
    logic [3:0] o;
    for (int k = 0; k < 4; k++) o[k] = mv[k];
    return o;
  endfunction

  function automatic logic [15:0] m_od();
    return {md[3], md[2], md[1], md[0]};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = 4'd0;
    end
    mcnt = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [3:0] d, input logic [1:0] s,
                       input logic v, input logic [3:0] r,
                       output logic rdy);
    logic acc;
    in_data   = d;
    in_sel    = s;
    in_valid  = v;
    out_ready = r;
    #1;
    rdy = in_ready;
    chk("in_ready", in_ready, m_rdy(s, r));
    @(posedge clk);
    acc = v && m_rdy(s, r);
    for (int k = 0; k < 4; k++) if (r[k]) mv[k] = 1'b0;
    if (acc) begin
      mv[s] = 1'b1;
      md[s] = d;
      mcnt  = (mcnt + 1) % 256;
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_ov());
    chk("out_data", out_data, m_od());
    chk("accept_cnt", accept_cnt, mcnt);
  endtask

  logic       rdy;
  logic       pv;
  logic       hold;
  logic [3:0] pd;
  logic [1:0] ps;

  initial begin
    vec[0]  = '{4'd2,  2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 16'h0200, 8'd1};
    vec[1]  = '{4'd0,  2'd2, 1'b0, 4'b0000, 1'b0, 4'b0100, 16'h0200, 8'd1};
    vec[2]  = '{4'd0,  2'd1, 1'b0, 4'b0000, 1'b1, 4'b0100, 16'h0200, 8'd1};
    vec[3]  = '{4'd5,  2'd0, 1'b1, 4'b0000, 1'b1, 4'b0101, 16'h0205, 8'd2};
    vec[4]  = '{4'd10, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h02A5, 8'd3};
    vec[5]  = '{4'd0,  2'd0, 1'b0, 4'b0100, 1'b0, 4'b0011, 16'h02A5, 8'd3};
    vec[6]  = '{4'd1,  2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h01A5, 8'd4};
    vec[7]  = '{4'd15, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'hF1A5, 8'd5};
    vec[8]  = '{4'd7,  2'd1, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'hF1A5, 8'd5};
    vec[9]  = '{4'd7,  2'd3, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'hF1A5, 8'd5};
    vec[10] = '{4'd9,  2'd0, 1'b1, 4'b0001, 1'b1, 4'b1111, 16'hF1A9, 8'd6};
    vec[11] = '{4'd0,  2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'hF1A9, 8'd6};
    vec[12] = '{4'd3,  2'd1, 1'b1, 4'b0010, 1'b1, 4'b0010, 16'hF139, 8'd7};

    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_accept_cnt", accept_cnt, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vec[i].d, vec[i].s, vec[i].v, vec[i].r, rdy);
      chk($sformatf("vec%0d_rdy", i), rdy, vec[i].erdy);
      chk($sformatf("vec%0d_ov", i), out_valid, vec[i].eov);
      chk($sformatf("vec%0d_data", i), out_data, vec[i].edata);
      chk($sformatf("vec%0d_cnt", i), accept_cnt, vec[i].ecnt);
    end

    // fill every slot, then reset asynchronously between edges
    for (int k = 0; k < 4; k++) cycle(4'(k + 4), 2'(k), 1'b1, 4'b0000, rdy);
    chk("full_ov", out_valid, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", out_valid, 4'b0000);
    chk("async_rst_cnt", accept_cnt, 8'd0);
    chk("async_rst_data", out_data, 16'h0000);
    in_valid = 1'b0;
    in_sel   = 2'd3;
    #1;
    chk("async_rst_rdy", in_ready, 1'b1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'd6, 2'd1, 1'b1, 4'b0000, rdy);
    chk("resume_ov", out_valid, 4'b0010);
    chk("resume_cnt", accept_cnt, 8'd1);

    // 256 back-to-back accepts on ch3 while it drains every cycle
    for (int i = 0; i < 256; i++) begin
      cycle(4'(i), 2'd3, 1'b1, 4'b1000, rdy);
      chk("b2b_rdy", rdy, 1'b1);
      chk("b2b_ov3", out_valid[3], 1'b1);
    end
    chk("wrap_cnt", accept_cnt, 8'd1);
    chk("wrap_ch3", out_data[15:12], 4'hF);

    // random traffic, producer holds a stalled word stable
    hold = 1'b0;
    pv   = 1'b0;
    pd   = '0;
    ps   = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 4'($urandom);
        ps = 2'($urandom);
      end
      cycle(pd, ps, pv, 4'($urandom), rdy);
      hold = pv && !rdy;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
